seq_divider: RTL and testbench

- Sequential restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient + 8-bit remainder.
- Inverse datapath of the team's start/done shift-add multiplier top; used to check products (d_out / b == a) and to drive the same display path.
- One quotient bit per clock; start/done handshake identical in style to the multiplier's.

---
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider producing one quotient bit per
// clock. A start in IDLE latches the operands; done_flag pulses for one cycle
// when quotient/remainder are valid. A zero divisor short-circuits to DONE
// with all-ones results and div_by_zero set.
module seq_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  done_flag,
    output logic                  busy,
    output logic                  div_by_zero
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_shift;    // dividend bits still to be consumed, MSB first
    // The partial remainder is always below the divisor between steps, so the
    // top bit of the (DIVISOR_W+1)-bit remainder is always 0 and is not stored.
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic [CNT_W-1:0]      r_count;

    logic [DIVISOR_W:0]    w_trial;
    logic                  w_fits;
    logic [DIVISOR_W-1:0]  w_rem_next;

    // Trial remainder: previous remainder shifted left with the next dividend bit.
    assign w_trial = {r_rem, r_shift[DIVIDEND_W-1]};
    // Unsigned compare at DIVISOR_W+1 bits decides the quotient bit.
    assign w_fits  = (w_trial >= {1'b0, r_divisor});
    // When the divisor fits, trial < 2*divisor, so the difference fits in
    // DIVISOR_W bits and the low-bit subtraction is exact.
    assign w_rem_next = w_fits ? (w_trial[DIVISOR_W-1:0] - r_divisor)
                               : w_trial[DIVISOR_W-1:0];

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see the pre-edge
        // values; a blocking = would let later statements read new values.
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done_flag   <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_divisor   <= divisor;
                        r_shift     <= dividend;
                        r_rem       <= '0;
                        r_count     <= '0;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '1;
                            div_by_zero <= 1'b1;
                            done_flag   <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quotient <= {quotient[DIVIDEND_W-2:0], w_fits};
                    r_shift  <= {r_shift[DIVIDEND_W-2:0], 1'b0};
                    r_rem    <= w_rem_next;
                    r_count  <= r_count + CNT_W'(1);
                    if (r_count == LAST_STEP) begin
                        remainder <= w_rem_next;
                        done_flag <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against a
// plain-arithmetic reference (/ and %), including latency, busy window,
// divide-by-zero, ignored starts, back-to-back starts and mid-CALC reset.
module tb_seq_divider;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          done_flag;
    logic          busy;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done_flag   (done_flag),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: straight integer division.
    function automatic void ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                    output logic [DW-1:0] q, output logic [VW-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1;
            r = '1;
            z = 1'b1;
        end else begin
            q = DW'(int'(a) / int'(b));
            r = VW'(int'(a) % int'(b));
            z = 1'b0;
        end
    endfunction

    // Issue one operation from IDLE and wait (bounded) for done_flag.
    // Returns with the bench sampling the DONE cycle; lat counts edges after the start edge.
    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        while (!done_flag && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({quotient, remainder, done_flag, busy, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got q=%h r=%h d=%b b=%b z=%b exp all zero",
                     quotient, remainder, done_flag, busy, div_by_zero);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done_flag);
        end
    endtask

    task automatic test_directed();
        logic [DW-1:0] a_tab [6] = '{16'h8100, 16'hFFFF, 16'hFFFF, 16'h000A, 16'h0000, 16'h0F00};
        logic [VW-1:0] b_tab [6] = '{8'h13,    8'hF1,    8'h01,    8'h0B,    8'h35,    8'h44};
        logic [DW-1:0] q_tab [6] = '{16'h06CA, 16'h010F, 16'hFFFF, 16'h0000, 16'h0000, 16'h0038};
        logic [VW-1:0] r_tab [6] = '{8'h02,    8'hE0,    8'h00,    8'h0A,    8'h00,    8'h20};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(a_tab[i], b_tab[i], lat);
            checks++;
            if (lat !== DW) begin
                errors++;
                $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, DW);
            end
            checks++;
            if (quotient !== q_tab[i] || remainder !== r_tab[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL dir_result[%0d] got q=%h r=%h z=%b exp q=%h r=%h z=0",
                         i, quotient, remainder, div_by_zero, q_tab[i], r_tab[i]);
            end
            tick();
            checks++;
            if (done_flag !== 1'b0 || busy !== 1'b0 || quotient !== q_tab[i] || remainder !== r_tab[i]) begin
                errors++;
                $display("FAIL dir_hold[%0d] got d=%b b=%b q=%h r=%h exp d=0 b=0 q=%h r=%h",
                         i, done_flag, busy, quotient, remainder, q_tab[i], r_tab[i]);
            end
        end
    endtask

    task automatic test_busy_window();
        int n_busy = 0;
        int n_done = 0;
        dividend = 16'h8100;
        divisor  = 8'h13;
        start    = 1'b1;
        tick();
        start = 1'b0;
        while (busy && n_busy < 40) begin
            n_busy++;
            if (done_flag) n_done++;
            tick();
        end
        checks++;
        if (n_busy !== DW + 1) begin
            errors++;
            $display("FAIL busy_cycles got %0d exp %0d", n_busy, DW + 1);
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL done_pulse_count got %0d exp 1", n_done);
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        run_op(16'h00FF, 8'h00, lat);
        checks++;
        if (lat !== 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dbz_latency got lat=%0d busy=%b exp lat=0 busy=1", lat, busy);
        end
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 8'hFF || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result got q=%h r=%h z=%b exp q=ffff r=ff z=1",
                     quotient, remainder, div_by_zero);
        end
        tick();
        checks++;
        if (done_flag !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1 || quotient !== 16'hFFFF) begin
            errors++;
            $display("FAIL dbz_hold got d=%b b=%b z=%b q=%h exp d=0 b=0 z=1 q=ffff",
                     done_flag, busy, div_by_zero, quotient);
        end
        run_op(16'h0F00, 8'h44, lat);
        checks++;
        if (lat !== DW || quotient !== 16'h0038 || remainder !== 8'h20 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dbz_clear got lat=%0d q=%h r=%h z=%b exp lat=%0d q=0038 r=20 z=0",
                     lat, quotient, remainder, div_by_zero, DW);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [DW-1:0] a, eq;
        logic [VW-1:0] b, er;
        logic          ez;
        int            lat;
        int            n_busy = 0;
        a = DW'($urandom);
        b = VW'($urandom_range(1, 255));
        ref_div(a, b, eq, er, ez);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        repeat (4) begin tick(); lat++; end
        dividend = ~a;
        divisor  = b ^ 8'h5A;
        start    = 1'b1;
        repeat (2) begin tick(); lat++; end
        start = 1'b0;
        while (!done_flag && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== DW || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d q=%h r=%h z=%b exp lat=%0d q=%h r=%h z=%b",
                     lat, quotient, remainder, div_by_zero, DW, eq, er, ez);
        end
        repeat (4) begin
            tick();
            if (busy) n_busy++;
        end
        checks++;
        if (n_busy !== 0) begin
            errors++;
            $display("FAIL no_queued_start got busy_cycles=%0d exp 0", n_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a1, a2, eq1, eq2, q1, q2;
        logic [VW-1:0] b1, b2, er1, er2, r1, r2;
        logic          ez1, ez2;
        logic          prev_busy;
        int            t_first = -1;
        int            t_second = -1;
        int            n_done = 0;
        a1 = DW'($urandom); b1 = VW'($urandom_range(1, 255));
        a2 = DW'($urandom); b2 = VW'($urandom_range(1, 255));
        ref_div(a1, b1, eq1, er1, ez1);
        ref_div(a2, b2, eq2, er2, ez2);
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        dividend  = a1;
        divisor   = b1;
        start     = 1'b1;
        prev_busy = busy;
        for (int cyc = 1; cyc <= 60 && n_done < 2; cyc++) begin
            tick();
            if (busy && !prev_busy) begin
                if (t_first < 0) begin
                    t_first  = cyc;
                    dividend = a2;
                    divisor  = b2;
                end else if (t_second < 0) begin
                    t_second = cyc;
                end
            end
            if (done_flag) begin
                if (n_done == 0) begin q1 = quotient; r1 = remainder; end
                else begin q2 = quotient; r2 = remainder; end
                n_done++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        checks++;
        if (t_first < 0 || t_second - t_first !== DW + 2) begin
            errors++;
            $display("FAIL b2b_spacing got first=%0d second=%0d exp spacing %0d",
                     t_first, t_second, DW + 2);
        end
        checks++;
        if (q1 !== eq1 || r1 !== er1) begin
            errors++;
            $display("FAIL b2b_first got q=%h r=%h exp q=%h r=%h", q1, r1, eq1, er1);
        end
        checks++;
        if (q2 !== eq2 || r2 !== er2) begin
            errors++;
            $display("FAIL b2b_second got q=%h r=%h exp q=%h r=%h", q2, r2, eq2, er2);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_calc();
        logic [DW-1:0] a, eq;
        logic [VW-1:0] b, er;
        logic          ez;
        int            lat;
        int            n_done = 0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom_range(1, 255));
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({quotient, remainder, done_flag, busy, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got q=%h r=%h d=%b b=%b z=%b exp all zero",
                     quotient, remainder, done_flag, busy, div_by_zero);
        end
        repeat (20) begin
            tick();
            if (done_flag || busy) n_done++;
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL midreset_no_done got active_cycles=%0d exp 0", n_done);
        end
        a = DW'($urandom);
        b = VW'($urandom_range(1, 255));
        ref_div(a, b, eq, er, ez);
        run_op(a, b, lat);
        checks++;
        if (lat !== DW || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
            errors++;
            $display("FAIL midreset_recover got lat=%0d q=%h r=%h z=%b exp lat=%0d q=%h r=%h z=%b",
                     lat, quotient, remainder, div_by_zero, DW, eq, er, ez);
        end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] a, eq;
        logic [VW-1:0] b, er;
        logic          ez;
        int            lat;
        int            exp_lat;
        for (int i = 0; i < 1000; i++) begin
            a = DW'($urandom);
            b = VW'($urandom);
            if (i % 97 == 0) b = '0;
            if (i % 89 == 0) a = DW'($urandom_range(0, 255));
            ref_div(a, b, eq, er, ez);
            exp_lat = (b == 0) ? 0 : DW;
            run_op(a, b, lat);
            checks++;
            if (lat !== exp_lat) begin
                errors++;
                $display("FAIL rand_latency a=%h b=%h got %0d exp %0d", a, b, lat, exp_lat);
            end
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL rand_result a=%h b=%h got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                         a, b, quotient, remainder, div_by_zero, eq, er, ez);
            end
            if (b != 0) begin
                checks++;
                if (int'(quotient) * int'(b) + int'(remainder) !== int'(a) || remainder >= b) begin
                    errors++;
                    $display("FAIL rand_invariant a=%h b=%h got q=%h r=%h", a, b, quotient, remainder);
                end
            end
            tick();
        end
    endtask

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        test_reset();
        test_directed();
        test_busy_window();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
